// File: rtl/scarf_sram_pkg.sv
// scarf_sram_pkg: shared widths and cycle-FSM state encoding for the SCARF pattern SRAM loader
package scarf_sram_pkg;
  localparam int SRAM_AW    = 19;
  localparam int ADDR_BYTES = 3;
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT} sram_state_t;
endpackage

// File: rtl/scarf_sram_loader_cycle_fsm.sv
// sram_cycle_fsm: async-SRAM write/read strobe sequencer with programmable pulse and wait widths
module sram_cycle_fsm
  import scarf_sram_pkg::*;
#(
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [SRAM_AW-1:0] i_addr,
  input  logic [7:0]         i_wdata,
  output logic               o_idle,
  output logic               o_wr_done,
  output logic               o_rd_cap,
  output logic [SRAM_AW-1:0] o_addr,
  output logic [7:0]         o_dq_out,
  output logic               o_dq_oe,
  output logic               o_ce_n,
  output logic               o_oe_n,
  output logic               o_we_n
);
  sram_state_t r_state;
  logic [2:0]  r_cnt;
  assign o_idle    = r_state == IDLE;
  assign o_wr_done = r_state == W_HOLD;
  assign o_rd_cap  = r_state == R_WAIT && r_cnt == 3'd0;
  // strobes are registers with async reset so rst releases the pins without a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      o_addr   <= '0;
      o_dq_out <= 8'h00;
      o_dq_oe  <= 1'b0;
      o_ce_n   <= 1'b1;
      o_oe_n   <= 1'b1;
      o_we_n   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_wr) begin
            r_state  <= W_SETUP;
            o_addr   <= i_addr;
            o_dq_out <= i_wdata;
            o_dq_oe  <= 1'b1;
            o_ce_n   <= 1'b0;
          end else if (i_rd) begin
            r_state <= R_WAIT;
            r_cnt   <= 3'(RD_CYCLES - 1);
            o_addr  <= i_addr;
            o_ce_n  <= 1'b0;
            o_oe_n  <= 1'b0;
          end
        end
        W_SETUP: begin
          r_state <= W_PULSE;
          r_cnt   <= 3'(WE_CYCLES - 1);
          o_we_n  <= 1'b0;
        end
        W_PULSE: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_state <= W_HOLD;
            o_we_n  <= 1'b1;
          end
        end
        W_HOLD: begin
          r_state <= IDLE;
          o_dq_oe <= 1'b0;
          o_ce_n  <= 1'b1;
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_state <= IDLE;
            o_oe_n  <= 1'b1;
            o_ce_n  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/scarf_sram_loader.sv
// scarf_sram_loader: SCARF slave that loads/reads the pattern SRAM and hands it to the pattern generator
module scarf_sram_loader
  import scarf_sram_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID  = 7'd02,
  parameter int         WE_CYCLES = 2,
  parameter int         RD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_in,
  input  logic               data_in_valid,
  input  logic               data_in_finished,
  input  logic [6:0]         slave_id,
  input  logic               rnw,
  output logic [7:0]         read_data_out,
  input  logic               pattern_active,
  input  logic [SRAM_AW-1:0] sram_addr_pat_gen,
  output logic [7:0]         sram_data,
  output logic               write_dropped,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [7:0]         sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);
  logic               w_sel, w_strobe, w_last_addr, w_data_byte;
  logic               w_launch_wr, w_launch_rd, w_drop, w_pat_own;
  logic               w_idle, w_wr_done, w_rd_cap, w_fsm_ce_n, w_fsm_oe_n;
  logic [SRAM_AW-1:0] w_fsm_addr;
  logic [1:0]         r_bcnt;
  logic [SRAM_AW-1:0] r_addr;
  logic [7:0]         r_wdata, r_rdata;
  logic               r_wr_req, r_rd_req;
  assign w_sel       = slave_id == SLAVE_ID;
  assign w_strobe    = w_sel && data_in_valid;
  assign w_last_addr = w_strobe && r_bcnt == 2'(ADDR_BYTES - 1);
  assign w_data_byte = w_strobe && r_bcnt == 2'(ADDR_BYTES);
  assign w_launch_wr = w_data_byte && !rnw;
  assign w_launch_rd = (w_data_byte || w_last_addr) && rnw;
  assign w_drop      = (w_launch_wr || w_launch_rd) && pattern_active;
  assign w_pat_own   = pattern_active && w_idle;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt        <= 2'd0;
      r_addr        <= '0;
      r_wdata       <= 8'h00;
      r_rdata       <= 8'h00;
      r_wr_req      <= 1'b0;
      r_rd_req      <= 1'b0;
      write_dropped <= 1'b0;
      sram_data     <= 8'h00;
    end else begin
      r_bcnt <= data_in_finished ? 2'd0 : (w_strobe && r_bcnt != 2'd3) ? r_bcnt + 2'd1 : r_bcnt;
      // address bytes shift in MSB first; the 19-bit register keeps only the low bits of the 24
      if (w_strobe && r_bcnt < 2'(ADDR_BYTES))
        r_addr <= {r_addr[SRAM_AW-9:0], data_in};
      else if ((w_data_byte && (rnw || pattern_active)) || w_wr_done)
        r_addr <= r_addr + SRAM_AW'(1);
      // requests stay pending until the FSM is idle to take them
      r_wr_req      <= (w_launch_wr && !pattern_active) || (r_wr_req && !w_idle);
      r_rd_req      <= (w_launch_rd && !pattern_active) || (r_rd_req && !w_idle);
      r_wdata       <= w_launch_wr ? data_in : r_wdata;
      write_dropped <= write_dropped || w_drop;
      r_rdata       <= w_rd_cap ? sram_dq_in : data_in_finished ? 8'h00 : r_rdata;
      sram_data     <= w_pat_own ? sram_dq_in : sram_data;
    end
  end
  sram_cycle_fsm #(
    .WE_CYCLES(WE_CYCLES),
    .RD_CYCLES(RD_CYCLES)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .i_wr     (r_wr_req),
    .i_rd     (r_rd_req),
    .i_addr   (r_addr),
    .i_wdata  (r_wdata),
    .o_idle   (w_idle),
    .o_wr_done(w_wr_done),
    .o_rd_cap (w_rd_cap),
    .o_addr   (w_fsm_addr),
    .o_dq_out (sram_dq_out),
    .o_dq_oe  (sram_dq_oe),
    .o_ce_n   (w_fsm_ce_n),
    .o_oe_n   (w_fsm_oe_n),
    .o_we_n   (sram_we_n)
  );
  assign read_data_out = (w_sel && rnw) ? r_rdata : 8'h00;
  assign sram_addr     = w_pat_own ? sram_addr_pat_gen : w_fsm_addr;
  assign sram_ce_n     = w_fsm_ce_n && !w_pat_own;
  assign sram_oe_n     = w_fsm_oe_n && !w_pat_own;
endmodule

// File: tb/tb_scarf_sram_loader.sv
// tb_scarf_sram_loader: directed and randomized bursts checked against a transaction-level SRAM image
module tb_scarf_sram_loader;
  localparam logic [6:0] SID = 7'd2;
  localparam int         WE  = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_in_valid = 1'b0, data_in_finished = 1'b0, rnw = 1'b0, pattern_active = 1'b0;
  logic [6:0]  slave_id = 7'd0;
  logic [18:0] sram_addr_pat_gen = 19'h0;
  logic [7:0]  read_data_out, sram_data, sram_dq_out, sram_dq_in;
  logic        write_dropped, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [18:0] sram_addr;
  logic [7:0]  mem [0:524287] = '{default: 8'h00};
  logic [7:0]  exp_mem [int];
  logic [7:0]  wq [$];
  int          checks = 0, failures = 0, we_low = 0, ce_low = 0;

  scarf_sram_loader #(.SLAVE_ID(SID), .WE_CYCLES(WE), .RD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_finished(data_in_finished), .slave_id(slave_id), .rnw(rnw),
    .read_data_out(read_data_out), .pattern_active(pattern_active),
    .sram_addr_pat_gen(sram_addr_pat_gen), .sram_data(sram_data), .write_dropped(write_dropped),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;
  always @(posedge sram_we_n) if (!sram_ce_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  always @(posedge clk) begin
    if (!sram_we_n) we_low <= we_low + 1;
    if (!sram_ce_n) ce_low <= ce_low + 1;
  end

  function automatic logic [7:0] expv(input logic [18:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); data_in = b; data_in_valid = 1'b1;
    @(negedge clk); data_in_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic fin();
    @(negedge clk); data_in_finished = 1'b1;
    @(negedge clk); data_in_finished = 1'b0;
  endtask

  task automatic send_addr(input logic [23:0] a);
    send(a[23:16]); send(a[15:8]); send(a[7:0]);
  endtask

  task automatic write_burst(input logic [23:0] a);
    logic [18:0] p = a[18:0];
    bit live = (slave_id == SID) && !pattern_active;
    int w0;
    rnw = 1'b0;
    send_addr(a);
    foreach (wq[i]) begin
      w0 = we_low;
      send(wq[i]);
      chk("we_width", we_low - w0, live ? WE : 0);
      if (live) exp_mem[int'(p)] = wq[i];
      chk("sram_image", mem[p], expv(p));
      p++;
    end
    chk("rd_out_in_write", read_data_out, 0);
    fin();
  endtask

  task automatic read_burst(input logic [23:0] a, input int n);
    logic [18:0] p = a[18:0];
    bit live = slave_id == SID;
    rnw = 1'b1;
    send_addr(a);
    chk("rd_first", read_data_out, live ? expv(p) : 8'h00);
    for (int i = 1; i < n; i++) begin
      p++;
      send(8'h00);
      chk("rd_next", read_data_out, live ? expv(p) : 8'h00);
    end
    fin();
    chk("rd_after_fin", read_data_out, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [18:0] q, prev;
    int n, c0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_sram_data", sram_data, 0);
    chk("rst_dropped", write_dropped, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    rst = 1'b0;
    slave_id = SID;
    wq = '{8'hA5, 8'h5A, 8'hFF};
    write_burst(24'h000010);
    read_burst(24'h000010, 3);
    wq = '{8'h11, 8'h22};
    write_burst(24'h07FFFF);
    chk("wrap_top", mem[19'h7FFFF], 8'h11);
    chk("wrap_zero", mem[19'h00000], 8'h22);
    read_burst(24'h07FFFF, 2);
    wq = '{8'h3C};
    write_burst(24'hF80003);
    chk("upper_bits", mem[19'h00003], 8'h3C);
    read_burst(24'h000003, 1);
    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      n = $urandom_range(1, 4);
      wq.delete();
      repeat (n) wq.push_back(8'($urandom));
      write_burst(r[23:0]);
      read_burst({5'($urandom), r[18:0]}, n);
    end
    slave_id = SID + 7'd1;
    c0 = ce_low;
    wq = '{8'hEE};
    write_burst(24'h000010);
    read_burst(24'h000010, 2);
    chk("other_ce", ce_low - c0, 0);
    chk("other_mem", mem[19'h10], expv(19'h10));
    slave_id = SID;
    pattern_active = 1'b1;
    sram_addr_pat_gen = 19'h10;
    prev = 19'h10;
    @(negedge clk);
    chk("pat_addr0", sram_addr, 19'h10);
    chk("pat_ce_n", sram_ce_n, 0);
    chk("pat_oe_n", sram_oe_n, 0);
    chk("pat_we_n", sram_we_n, 1);
    chk("pat_dq_oe", sram_dq_oe, 0);
    chk("pat_data0", sram_data, expv(19'h10));
    for (int k = 0; k < 5; k++) begin
      q = 19'h0F + 19'($urandom_range(0, 4));
      sram_addr_pat_gen = q;
      #1 chk("pat_lag", sram_data, expv(prev));
      chk("pat_addr", sram_addr, q);
      @(negedge clk);
      chk("pat_data", sram_data, expv(q));
      prev = q;
    end
    wq = '{8'h77};
    write_burst(24'h000020);
    chk("dropped", write_dropped, 1);
    chk("pat_addr_hold", sram_addr, prev);
    pattern_active = 1'b0;
    @(negedge clk);
    chk("dropped_sticky", write_dropped, 1);
    read_burst(24'h000020, 1);
    rnw = 1'b0;
    send_addr(24'h000030);
    @(negedge clk); data_in = 8'h3C; data_in_valid = 1'b1;
    @(negedge clk); data_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_we_low", sram_we_n, 0);
    pattern_active = 1'b1;
    sram_addr_pat_gen = 19'h10;
    #1 chk("mid_addr_fsm", sram_addr, 19'h30);
    repeat (3) @(negedge clk);
    chk("mid_addr_pat", sram_addr, 19'h10);
    chk("mid_mem", mem[19'h30], 8'h3C);
    exp_mem[48] = 8'h3C;
    pattern_active = 1'b0;
    repeat (5) @(negedge clk);
    fin();
    read_burst(24'h000030, 1);
    rnw = 1'b0;
    send_addr(24'h000040);
    @(negedge clk); data_in = 8'h99; data_in_valid = 1'b1;
    @(negedge clk); data_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_we", sram_we_n, 0);
    chk("rst_pre_oe", sram_dq_oe, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_we", sram_we_n, 1);
    chk("rst_async_dq_oe", sram_dq_oe, 0);
    chk("rst_async_ce", sram_ce_n, 1);
    chk("rst_clear_drop", write_dropped, 0);
    @(negedge clk); rst = 1'b0;
    wq = '{8'hC3, 8'h3C};
    write_burst(24'h000050);
    read_burst(24'h000050, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scarf_sram_loader.md
# scarf_sram_loader

SCARF slave that loads and reads back the 512 KiB pattern SRAM and feeds `sram_data` to the pattern generator. It sits directly upstream of `scarf_pattern_generator`: while a pattern runs it owns the SRAM pins on the generator's behalf, and at all other times it serves host write/read bursts arriving on the shared SCARF byte bus. It generates the async-SRAM control strobes and auto-increments the address across bursts.

## Interface
- `SLAVE_ID`, default 7'd02: SCARF slave ID this block answers to.
- `WE_CYCLES`, default 2: width of the `sram_we_n` low pulse, in clk cycles (1..7).
- `RD_CYCLES`, default 2: SRAM access wait before read capture, in clk cycles (1..7).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 8: SCARF byte following the slave-ID byte.
- `data_in_valid` in 1: one-cycle strobe, `data_in` valid. Consecutive strobes are at least 8 clk apart.
- `data_in_finished` in 1: one-cycle strobe, transaction end.
- `slave_id` in 7: addressed slave, stable from the first `data_in_valid` until `data_in_finished`.
- `rnw` in 1: 1 = read burst, 0 = write burst.
- `read_data_out` out 8: read byte; 8'h00 when not selected (the bus is OR-combined).
- `pattern_active` in 1: from the pattern generator. The generator owns the SRAM while this is high.
- `sram_addr_pat_gen` in 19: pattern generator address.
- `sram_data` out 8: SRAM byte to the pattern generator.
- `write_dropped` out 1: sticky; set when a host access hits while `pattern_active` is high.
- `sram_addr` out 19, `sram_dq_out` out 8, `sram_dq_oe` out 1, `sram_dq_in` in 8, `sram_ce_n` out 1, `sram_oe_n` out 1, `sram_we_n` out 1: external async SRAM pins.

## Operation
**Selection and address phase**
- The block is selected when `slave_id==SLAVE_ID`.
- Byte counter `bcnt` counts `data_in_valid` strobes while selected. It clears on `data_in_finished` or `rst`.
- Bytes 0–2 form a 24-bit start address, MSB first. Only bits [18:0] are kept; bits [23:19] are ignored.
- On byte 2 with `rnw=1`, the block issues a prefetch read at the start address.

**Write burst** (`rnw=0`, byte 3 onward)
- Each byte launches one write cycle at `addr`.
- `addr` increments when the cycle completes.
- Wrap: 19'h7FFFF increments to 19'h00000.

**Read burst** (`rnw=1`, byte 3 onward)
- Each byte increments `addr`, then prefetches the byte at the new address.
- `read_data_out` holds the last captured byte.

**Cycle FSM** (sub-module `sram_cycle_fsm`)
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT.
- Write path: IDLE → W_SETUP (1 cycle) → W_PULSE (`WE_CYCLES` cycles) → W_HOLD (1 cycle) → IDLE.
  - W_SETUP: address and data driven, `sram_dq_oe=1`, `we_n=1`.
  - W_PULSE: `we_n=0`.
  - W_HOLD: `we_n=1`, data still driven.
- Read path: IDLE → R_WAIT (`RD_CYCLES` cycles, `oe_n=0`) → capture `sram_dq_in` into `read_data_out` → IDLE.

**Arbitration**
- While `pattern_active=1` and the FSM is IDLE:
  - `sram_addr=sram_addr_pat_gen`, `ce_n=0`, `oe_n=0`, `we_n=1`, `dq_oe=0`.
  - `sram_data` is `sram_dq_in`, registered.
- Host bytes arriving while `pattern_active=1` do not launch cycles and set `write_dropped`. `addr` still increments.
- If `pattern_active` rises mid-cycle, the in-flight cycle completes before the generator gets the pins.
- Firmware must not start a pattern during a load.

**Selection and reset**
- Outside a selected read, `read_data_out=8'h00`. The captured value reappears on the next selection only after a new capture.
- `rst` mid-cycle: the FSM returns to IDLE immediately and the strobes deassert asynchronously. That write is lost.

## Timing
Reset values:
- `read_data_out=0`, `sram_data=0`, `write_dropped=0`.
- `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`.
- `ce_n=1`, `oe_n=1`, `we_n=1`.
- FSM in IDLE, `addr=0`, `bcnt=0`.

Latencies:
- A `data_in_valid` seen at edge N gives FSM exit from IDLE at edge N+1.
- A write cycle lasts `WE_CYCLES`+2 cycles, which is at most 9, under the 8-cycle byte spacing plus 1 cycle of slack.
- Read capture happens at N+1+`RD_CYCLES`, so `read_data_out` is valid 3 cycles after the strobe with defaults.
- `sram_data` lags `sram_addr_pat_gen` by 1 cycle (registered) plus SRAM access time. The generator accounts for 2 cycles.
- `write_dropped` sets on the edge after the offending strobe. It clears only on `rst`.

Simultaneous strobes:
- `data_in_finished` and `data_in_valid` in the same cycle: the byte is processed, then `bcnt` clears.
- An in-flight cycle is never aborted by `data_in_finished`.

## Structure
- Package `scarf_sram_pkg`:
  - `SRAM_AW=19`.
  - `sram_state_t` enum (IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT).
  - `ADDR_BYTES=3`.
- Sub-module `sram_cycle_fsm`: strobe generation and pulse counters.
- Top: byte decode, address register, arbitration mux.

## Test plan
- **Write then read back:** write burst at addr 24'h000010 with data A5,5A,FF → SRAM model holds 0x10=A5, 0x11=5A, 0x12=FF. A read burst from 0x10 returns A5, 5A, FF; `we_n` low exactly 2 cycles per byte.
- **Wrap:** write at 24'h07FFFF with two bytes 11,22 → 0x7FFFF=11, 0x00000=22.
- **Upper address bits:** start address 24'hF80003 → writes land at 0x00003.
- **Pattern active:** with `pattern_active=1`, write byte 77 → no `we_n` pulse, `write_dropped=1`. `sram_addr` tracks `sram_addr_pat_gen`; `sram_data` equals model data 1 cycle late.
- **Mid-cycle handoff:** raise `pattern_active` during W_PULSE → the write completes and then `sram_addr` switches. Assert `rst` during W_PULSE → `we_n=1` and `dq_oe=0` without waiting for a clock edge.
- **Other slave:** a burst with `slave_id=SLAVE_ID+1` → no SRAM strobes, `read_data_out=0`.
